// File: rtl/xor_result_misr_pkg.sv
// Shared definitions for the XOR result MISR: word width, feedback polynomial
// and state encodings. Also used by the misr_step sub-module.
package xor_result_misr_pkg;

    localparam int          WORD_WIDTH = 20;
    localparam logic [19:0] MISR_POLY  = 20'h00009;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/xor_result_misr_if.sv
// Handshake and status bundle between a result producer and the MISR checker.
// XOR_MISR_TIMEOUT_EN adds the timeout status line.
interface xor_result_misr_if #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] expected_sig;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic             pass;
`ifdef XOR_MISR_TIMEOUT_EN
    logic             timeout;
`endif

    modport master (
`ifdef XOR_MISR_TIMEOUT_EN
        input  timeout,
`endif
        output start, in_valid, in_data, expected_sig,
        input  in_ready, signature, word_count, busy, done, pass
    );

    modport slave (
`ifdef XOR_MISR_TIMEOUT_EN
        output timeout,
`endif
        input  start, in_valid, in_data, expected_sig,
        output in_ready, signature, word_count, busy, done, pass
    );

endinterface

// File: rtl/xor_result_misr_misr_step.sv
// One MISR compaction step: shift left, fold the dropped MSB back through POLY,
// then XOR in the new data word. Purely combinational.
module misr_step
    import xor_result_misr_pkg::*;
#(
    parameter int               WIDTH = WORD_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY
) (
    input  logic [WIDTH-1:0] i_sig,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_next_sig
);

    logic [WIDTH-1:0] w_feedback;

    assign w_feedback = i_sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    assign o_next_sig = {i_sig[WIDTH-2:0], 1'b0} ^ w_feedback ^ i_data;

endmodule

// File: rtl/xor_result_misr.sv
// Response checker: compacts NUM_WORDS result words into a MISR and flags pass
// when the final signature matches expected_sig. XOR_MISR_TIMEOUT_EN adds an idle timeout.
module xor_result_misr
    import xor_result_misr_pkg::*;
#(
    parameter int               WIDTH     = WORD_WIDTH,
    parameter logic [WIDTH-1:0] POLY      = MISR_POLY,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b0}},
    parameter int               NUM_WORDS = 10,
    parameter int               CNT_W     = 16
`ifdef XOR_MISR_TIMEOUT_EN
    ,
    parameter int               TIMEOUT   = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    xor_result_misr_if.slave  bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [WIDTH-1:0] w_step_sig;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pass;
    logic             w_pass_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_restart;
    logic             w_timeout_hit;

    // in_ready is a registered copy of "state is RUN", so it doubles as the accept qualifier
    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_last    = (r_cnt == CNT_W'(NUM_WORDS - 1));
    assign w_restart = bus.start && (r_state != ST_RUN);

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .i_sig      (r_sig),
        .i_data     (bus.in_data),
        .o_next_sig (w_step_sig)
    );

`ifdef XOR_MISR_TIMEOUT_EN
    localparam int             TO_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TO_W-1:0] IDLE_MAX = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_idle;
    logic            r_timeout;

    assign w_timeout_hit = (r_idle == IDLE_MAX);

    // Idle-cycle counter and sticky timeout flag for the current run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle    <= {TO_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_restart) begin
            r_idle    <= {TO_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (r_state == ST_RUN && !w_accept) begin
            r_idle    <= r_idle + TO_W'(1'b1);
            r_timeout <= r_timeout | w_timeout_hit;
        end else begin
            r_idle    <= {TO_W{1'b0}};
            r_timeout <= r_timeout;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Next-state, signature, counter and pass computation
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_sig_nxt   = SEED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_pass_nxt  = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_sig_nxt = w_step_sig;
                    w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                    if (w_last) begin
                        // pass is judged on the signature that includes the final word
                        w_state_nxt = ST_DONE;
                        w_pass_nxt  = (w_step_sig == bus.expected_sig);
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_DONE;
                    w_pass_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and decoded status flags, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sig      <= SEED;
            r_cnt      <= {CNT_W{1'b0}};
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sig      <= w_sig_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pass     <= w_pass_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_in_ready <= (w_state_nxt == ST_RUN);
        end
    end

    assign bus.signature  = r_sig;
    assign bus.word_count = r_cnt;
    assign bus.pass       = r_pass;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.in_ready   = r_in_ready;

endmodule

// File: tb/tb_xor_result_misr.sv
// Directed self-checking bench for xor_result_misr; three instances cover the
// NUM_WORDS=2, NUM_WORDS=1/SEED=0x80000 and NUM_WORDS=10 scenarios.
module tb_xor_result_misr;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    xor_result_misr_if #(.WIDTH(20), .CNT_W(16)) a_if ();
    xor_result_misr_if #(.WIDTH(20), .CNT_W(16)) b_if ();
    xor_result_misr_if #(.WIDTH(20), .CNT_W(16)) c_if ();

    xor_result_misr #(.SEED(20'h00000), .NUM_WORDS(2)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    xor_result_misr #(.SEED(20'h80000), .NUM_WORDS(1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
`ifdef XOR_MISR_TIMEOUT_EN
    xor_result_misr #(.SEED(20'h00000), .NUM_WORDS(10), .TIMEOUT(8)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
`else
    xor_result_misr #(.SEED(20'h00000), .NUM_WORDS(10)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
`endif

    logic [19:0] words [10] = '{20'h00001, 20'h00002, 20'h00004, 20'h80000, 20'h00000,
                                20'h0000F, 20'h12345, 20'hFFFFF, 20'h00000, 20'h00001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] misr_model(input logic [19:0] sig, input logic [19:0] data);
        return {sig[18:0], 1'b0} ^ (sig[19] ? 20'h00009 : 20'h00000) ^ data;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] model;
        int          idx;
        {a_if.start, a_if.in_valid, a_if.in_data, a_if.expected_sig} = '0;
        {b_if.start, b_if.in_valid, b_if.in_data, b_if.expected_sig} = '0;
        {c_if.start, c_if.in_valid, c_if.in_data, c_if.expected_sig} = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #11 rst = 1'b0;

        chk("rst_a_sig", a_if.signature, 32'h00000);
        chk("rst_b_sig", b_if.signature, 32'h80000);
        chk("rst_a_cnt", a_if.word_count, 32'd0);
        chk("rst_a_flags", {a_if.busy, a_if.done, a_if.pass, a_if.in_ready}, 32'b0000);

        // IDLE must not accept even with in_valid high
        a_if.in_valid = 1'b1;
        a_if.in_data  = 20'h00001;
        tick();
        chk("idle_ready", a_if.in_ready, 32'd0);
        chk("idle_cnt", a_if.word_count, 32'd0);

        // Basic compaction: 0x00001 then 0x00002
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        chk("a_run", {a_if.busy, a_if.in_ready, a_if.done}, 32'b110);
        tick();
        chk("a_sig1", a_if.signature, 32'h00001);
        chk("a_done_early", a_if.done, 32'd0);
        a_if.in_data      = 20'h00002;
        a_if.expected_sig = 20'h00000;
        tick();
        a_if.in_valid = 1'b0;
        chk("a_sig2", a_if.signature, 32'h00000);
        chk("a_cnt2", a_if.word_count, 32'd2);
        chk("a_done", {a_if.done, a_if.busy, a_if.in_ready}, 32'b100);
        chk("a_pass", a_if.pass, 32'd1);
        a_if.expected_sig = 20'h12345;
        a_if.in_valid     = 1'b1;
        a_if.in_data      = 20'hFFFFF;
        tick();
        a_if.in_valid = 1'b0;
        chk("a_hold_pass", a_if.pass, 32'd1);
        chk("a_hold_sig", a_if.signature, 32'h00000);
        chk("a_hold_cnt", a_if.word_count, 32'd2);

        // Feedback tap: SEED 0x80000, data 0 -> 0x00009
        b_if.in_valid     = 1'b1;
        b_if.in_data      = 20'h00000;
        b_if.expected_sig = 20'h00008;
        b_if.start        = 1'b1;
        tick();
        b_if.start = 1'b0;
        tick();
        b_if.in_valid = 1'b0;
        chk("b_sig", b_if.signature, 32'h00009);
        chk("b_cnt", b_if.word_count, 32'd1);
        chk("b_done", b_if.done, 32'd1);
        chk("b_pass", b_if.pass, 32'd0);

        // Restart from DONE reloads SEED and clears pass
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        chk("b_restart_flags", {b_if.busy, b_if.done, b_if.pass}, 32'b100);
        chk("b_restart_sig", b_if.signature, 32'h80000);
        chk("b_restart_cnt", b_if.word_count, 32'd0);
        b_if.in_valid     = 1'b1;
        b_if.expected_sig = 20'h00009;
        tick();
        b_if.in_valid = 1'b0;
        chk("b_pass2", b_if.pass, 32'd1);

        // Ten words with stalls and a start pulse mid-run
        c_if.expected_sig = 20'h6E61E;
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
        idx   = 0;
        model = 20'h00000;
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            c_if.in_valid = (cyc % 3 != 1);
            c_if.in_data  = words[idx];
            c_if.start    = (cyc == 7);
            tick();
            if (c_if.in_valid) begin
                model = misr_model(model, words[idx]);
                idx++;
                if (idx == 4) chk("c_sig4", c_if.signature, 32'h80008);
            end
        end
        c_if.in_valid = 1'b0;
        c_if.start    = 1'b0;
        chk("c_sig10", c_if.signature, 32'h6E61E);
        chk("c_model", c_if.signature, {12'h000, model});
        chk("c_cnt", c_if.word_count, 32'd10);
        chk("c_done_pass", {c_if.done, c_if.pass, c_if.busy}, 32'b110);
        c_if.in_valid = 1'b1;
        c_if.in_data  = 20'h55555;
        tick();
        tick();
        c_if.in_valid = 1'b0;
        chk("c_post_sig", c_if.signature, 32'h6E61E);
        chk("c_post_cnt", c_if.word_count, 32'd10);

`ifdef XOR_MISR_TIMEOUT_EN
        // Three words then silence: timeout after 8 idle cycles
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_if.in_valid = 1'b1;
            c_if.in_data  = words[i];
            tick();
        end
        c_if.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", c_if.done, 32'd0);
        tick();
        chk("to_fire", {c_if.done, c_if.timeout, c_if.pass}, 32'b110);
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
        chk("to_clear", {c_if.busy, c_if.timeout}, 32'b10);
`else
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
`endif

        // Five words then an asynchronous reset mid-run
        for (int i = 0; i < 5; i++) begin
            c_if.in_valid = 1'b1;
            c_if.in_data  = words[i];
            tick();
        end
        c_if.in_valid = 1'b0;
        chk("c5_sig", c_if.signature, 32'h00019);
        chk("c5_cnt", c_if.word_count, 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_sig", c_if.signature, 32'h00000);
        chk("arst_cnt", c_if.word_count, 32'd0);
        chk("arst_flags", {c_if.busy, c_if.done, c_if.pass, c_if.in_ready}, 32'b0000);
        chk("arst_b_sig", b_if.signature, 32'h80000);
        tick();
        rst = 1'b0;
        c_if.in_valid = 1'b1;
        tick();
        c_if.in_valid = 1'b0;
        chk("post_rst_idle", {c_if.busy, c_if.done, c_if.in_ready}, 32'b000);
        chk("post_rst_cnt", c_if.word_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
